io_sw_debounce: RTL and testbench

IO_SW_DEBOUNCE -- requirements
Module: io_sw_debounce

---
 rtl/io_sw_pkg.sv | 8 +
 rtl/io_sw_debounce_bit.sv | 46 ++++
 rtl/io_sw_debounce.sv | 50 +++++
 tb/tb_io_sw_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/io_sw_pkg.sv
// Shared constants for the board-switch debouncer.
package io_sw_pkg;

   localparam int STABLE_CNT_DEFAULT = 500000;
   localparam int STABLE_CNT_SIM     = 4;
   localparam int SW_W               = 32;

endpackage

// File: rtl/io_sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, mismatch counter and debounced output flop.
module io_sw_debounce_bit #(
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_bit,
   output logic o_flip
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CNT - 1);

   (* ASYNC_REG = "TRUE" *) logic r_sync1;
   (* ASYNC_REG = "TRUE" *) logic r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bit;
   logic             w_mismatch;

   assign w_mismatch = (r_sync2 != r_bit);
   // The flip happens on the edge that would otherwise take the count to STABLE_CNT.
   assign o_flip     = w_mismatch && (r_cnt == LP_LAST);
   assign o_bit      = r_bit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_bit   <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (o_flip) begin
            r_cnt <= '0;
            r_bit <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/io_sw_debounce.sv
// 32-bit switch debouncer with sticky per-bit change events and a change pulse.
module io_sw_debounce
   import io_sw_pkg::*;
#(
   parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
   parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [SW_W-1:0] i_sw_raw,
   input  logic            i_event_clr,
   output logic [SW_W-1:0] o_io_sw,
   output logic [SW_W-1:0] o_sw_event,
   output logic            o_sw_change
);

   logic [SW_W-1:0] w_bit;
   logic [SW_W-1:0] w_flip;
   logic [SW_W-1:0] r_event;
   logic            r_change;

   for (genvar g = 0; g < SW_W; g++) begin : g_bit
      io_sw_debounce_bit #(
         .STABLE_CNT (STABLE_CNT),
         .CNT_W      (CNT_W)
      ) u_bit (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_raw  (i_sw_raw[g]),
         .o_bit  (w_bit[g]),
         .o_flip (w_flip[g])
      );
   end

   // Set wins over clear so a flip coinciding with a clear is never lost.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_event  <= '0;
         r_change <= 1'b0;
      end else begin
         r_event  <= (r_event & ~{SW_W{i_event_clr}}) | w_flip;
         r_change <= |w_flip;
      end
   end

   assign o_io_sw     = w_bit;
   assign o_sw_event  = r_event;
   assign o_sw_change = r_change;

endmodule

// File: tb/tb_io_sw_debounce.sv
// Self-checking bench for io_sw_debounce with STABLE_CNT = 4 (6-edge latency).
module tb_io_sw_debounce;

   localparam int SC = io_sw_pkg::STABLE_CNT_SIM;

   typedef struct {
      logic [31:0] sw;
      logic [31:0] ev;
      logic        ch;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_sw_raw = '0;
   logic        i_event_clr = 1'b0;
   logic [31:0] o_io_sw;
   logic [31:0] o_sw_event;
   logic        o_sw_change;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   io_sw_debounce #(.STABLE_CNT(SC)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_sw_raw    (i_sw_raw),
      .i_event_clr (i_event_clr),
      .o_io_sw     (o_io_sw),
      .o_sw_event  (o_sw_event),
      .o_sw_change (o_sw_change)
   );

   always #5 i_clk = ~i_clk;

   function automatic void push_exp(input logic [31:0] sw, input logic [31:0] ev, input logic ch);
      exp_t e;
      e.sw = sw; e.ev = ev; e.ch = ch;
      exp_q.push_back(e);
   endfunction

   // Queue the per-edge expectation of a flip from (sw0,ev0) to (sw1,ev1) 2+SC edges after a raw edge.
   function automatic void push_flip(input logic [31:0] sw0, input logic [31:0] ev0,
                                     input logic [31:0] sw1, input logic [31:0] ev1);
      for (int k = 1; k < 2 + SC; k++) push_exp(sw0, ev0, 1'b0);
      push_exp(sw1, ev1, 1'b1);
      push_exp(sw1, ev1, 1'b0);
   endfunction

   task automatic test_reset();
      exp_t e;
      i_rst = 1'b1;
      i_sw_raw = '0;
      #1;
      n_checks++;
      if ({o_io_sw, o_sw_event, o_sw_change} !== 65'd0) begin
         n_errors++;
         $display("FAIL reset_immediate: got sw=%h ev=%h ch=%b, want all 0", o_io_sw, o_sw_event, o_sw_change);
      end
      for (int k = 0; k < 4; k++) push_exp('0, '0, 1'b0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) push_exp('0, '0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL reset_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL reset_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL reset_ch: got %b want %b", o_sw_change, e.ch); end
      end
   endtask

   task automatic test_rise_bit0();
      exp_t e;
      i_sw_raw = 32'h1;
      push_flip('0, '0, 32'h1, 32'h1);
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL rise_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL rise_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL rise_ch: got %b want %b", o_sw_change, e.ch); end
      end
   endtask

   task automatic test_glitch_bit3();
      exp_t e;
      int   k;
      i_sw_raw = 32'h9;
      for (int j = 0; j < 10; j++) push_exp(32'h1, 32'h1, 1'b0);
      k = 0;
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         k++;
         if (k == 3) i_sw_raw = 32'h1;
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL glitch_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL glitch_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL glitch_ch: got %b want %b", o_sw_change, e.ch); end
      end
   endtask

   task automatic test_clr_same_edge();
      exp_t e;
      int   k;
      i_sw_raw = 32'h21;
      push_flip(32'h1, 32'h1, 32'h21, 32'h20);
      push_exp(32'h21, 32'h0, 1'b0);
      push_exp(32'h21, 32'h0, 1'b0);
      k = 0;
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         k++;
         // Clear sampled on the flip edge (6), then a lone clear sampled on edge 8.
         i_event_clr = (k == 5 || k == 7);
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL clr_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL clr_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL clr_ch: got %b want %b", o_sw_change, e.ch); end
      end
      i_event_clr = 1'b0;
   endtask

   task automatic test_reset_mid_count();
      exp_t e;
      i_sw_raw = 32'hA1;
      repeat (3) @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      n_checks++;
      if ({o_io_sw, o_sw_event, o_sw_change} !== 65'd0) begin
         n_errors++;
         $display("FAIL midrst_immediate: got sw=%h ev=%h ch=%b, want all 0", o_io_sw, o_sw_event, o_sw_change);
      end
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      push_flip('0, '0, 32'hA1, 32'hA1);
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL midrst_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL midrst_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL midrst_ch: got %b want %b", o_sw_change, e.ch); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   k;
      i_rst = 1'b1;
      i_sw_raw = '0;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_sw_raw = 32'h2;
      for (int j = 1; j < 2 + SC; j++) push_exp('0, '0, 1'b0);
      push_exp(32'h2, 32'h2, 1'b1);
      push_exp(32'h6, 32'h6, 1'b1);
      push_exp(32'h6, 32'h6, 1'b0);
      k = 0;
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         k++;
         if (k == 1) i_sw_raw = 32'h6;
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL b2b_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL b2b_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL b2b_ch: got %b want %b", o_sw_change, e.ch); end
      end
   endtask

   task automatic test_all_bits();
      exp_t e;
      i_rst = 1'b1;
      i_sw_raw = '0;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_sw_raw = 32'hFFFF_FFFF;
      push_flip('0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge i_clk); #1;
         e = exp_q.pop_front();
         n_checks += 3;
         if (o_io_sw !== e.sw) begin n_errors++; $display("FAIL all_sw: got %h want %h", o_io_sw, e.sw); end
         if (o_sw_event !== e.ev) begin n_errors++; $display("FAIL all_ev: got %h want %h", o_sw_event, e.ev); end
         if (o_sw_change !== e.ch) begin n_errors++; $display("FAIL all_ch: got %b want %b", o_sw_change, e.ch); end
      end
   endtask

   initial begin
      test_reset();
      test_rise_bit0();
      test_glitch_bit3();
      test_clr_same_edge();
      test_reset_mid_count();
      test_back_to_back();
      test_all_bits();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
